// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: 2-flop sync, tick-paced debounce, press/release/long/repeat pulses.
// Latency: 2 sync cycles plus DB_TICKS ticks to accept an edge; events registered one cycle after the deciding tick; no backpressure.
module key_debounce_multi #(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int TICK_DIV     = 100000,
  parameter int DB_TICKS     = 16,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int MAX_LR  = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CNT_MAX = (MAX_LR > DB_TICKS) ? MAX_LR : DB_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TICK_W  = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]  DB_C     = CNT_W'(DB_TICKS);
  localparam logic [CNT_W-1:0]  LONG_C   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0]  REPEAT_C = CNT_W'(REPEAT_TICKS);
  localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICK_DIV - 1);
  localparam logic [N_KEYS-1:0] PIN_RELEASED = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_HELD     = 3'd2,
    ST_LONG     = 3'd3,
    ST_REL_DB   = 3'd4
  } state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_TOP);

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Synchronisers reset to the released pin level so reset never looks like a press.
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] key_s;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= PIN_RELEASED;
      sync2 <= PIN_RELEASED;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  for (genvar i = 0; i < N_KEYS; i++) begin : ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             long_q;
    logic             long_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;
    logic             lng_q;
    logic             lng_d;
    logic             rep_q;
    logic             rep_d;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        long_q  <= 1'b0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        lng_q   <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        long_q  <= long_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        lng_q   <= lng_d;
        rep_q   <= rep_d;
      end
    end

    always_comb begin
      state_d = state_q;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (key_s[i]) state_d = (DB_TICKS == 1) ? ST_HELD : ST_PRESS_DB;
          end
          ST_PRESS_DB: begin
            if (!key_s[i])           state_d = ST_IDLE;
            else if (cnt_inc == DB_C) state_d = ST_HELD;
          end
          ST_HELD: begin
            if (!key_s[i])             state_d = (DB_TICKS == 1) ? ST_IDLE : ST_REL_DB;
            else if (cnt_inc == LONG_C) state_d = ST_LONG;
          end
          ST_LONG: begin
            if (!key_s[i]) state_d = (DB_TICKS == 1) ? ST_IDLE : ST_REL_DB;
          end
          ST_REL_DB: begin
            if (key_s[i])             state_d = long_q ? ST_LONG : ST_HELD;
            else if (cnt_inc == DB_C) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_comb begin
      cnt_d   = cnt_q;
      long_d  = long_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      lng_d   = 1'b0;
      rep_d   = 1'b0;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (key_s[i]) begin
              if (DB_TICKS == 1) begin
                cnt_d   = '0;
                lvl_d   = 1'b1;
                press_d = 1'b1;
              end else begin
                cnt_d = CNT_W'(1);
              end
            end
          end
          ST_PRESS_DB: begin
            if (!key_s[i]) begin
              cnt_d = '0;
            end else if (cnt_inc == DB_C) begin
              cnt_d   = '0;
              lvl_d   = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_HELD, ST_LONG: begin
            if (!key_s[i]) begin
              if (DB_TICKS == 1) begin
                cnt_d  = '0;
                lvl_d  = 1'b0;
                rel_d  = 1'b1;
                long_d = 1'b0;
              end else begin
                cnt_d = CNT_W'(1);
              end
            end else if (state_q == ST_HELD) begin
              if (cnt_inc == LONG_C) begin
                cnt_d  = '0;
                long_d = 1'b1;
                lng_d  = 1'b1;
              end else begin
                cnt_d = cnt_inc;
              end
            end else if (REPEAT_TICKS > 0) begin
              if (cnt_inc == REPEAT_C) begin
                cnt_d = '0;
                rep_d = 1'b1;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          end
          ST_REL_DB: begin
            // A bounce back to pressed resumes the hold silently with a fresh count.
            if (key_s[i]) begin
              cnt_d = '0;
            end else if (cnt_inc == DB_C) begin
              cnt_d  = '0;
              lvl_d  = 1'b0;
              rel_d  = 1'b1;
              long_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            cnt_d  = '0;
            long_d = 1'b0;
            lvl_d  = 1'b0;
          end
        endcase
      end
    end

    assign key_level[i]   = lvl_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = rel_q;
    assign key_long[i]    = lng_q;
    assign key_repeat[i]  = rep_q;
  end

endmodule
